serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder for the arithmetic datapath.
- Loads two operands and a carry-in, then adds one bit per clock, LSB first, through a single 1-bit adder cell with a registered carry.
- Returns a parallel sum and carry-out with a done pulse.
- Smaller-area alternative to the ripple-carry adder. It both feeds the adder cell its operand and carry bits and consumes the cell's sum and carry outputs.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A; captured on an accepted start
- b  input  WIDTH  operand B; captured on an accepted start
- cin  input  1  carry-in; captured on an accepted start
- busy  output  1  high while bits are being shifted
- done  output  1  one-cycle pulse when sum/cout are updated
- sum  output  WIDTH  result register; holds the last result
- cout  output  1  final carry-out; holds the last result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (rst_n=0, takes effect immediately):
  - state=IDLE, bit counter=0.
  - Operand shift registers=0, carry flop=0, partial-sum shift register=0.
  - busy=0, done=0, sum=0, cout=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 at an edge: load a, b and partial-sum (0) registers, carry flop<=cin, count<=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1):
  - Each edge, the adder cell combines the LSBs of the A and B shift registers with the carry flop.
  - Sum bit shifts into the MSB of the partial-sum register; A and B shift right (zero fill); carry flop takes the cell's carry; count<=count+1.
  - When count==WIDTH-1 at the edge, the last bit is processed and the state goes to DONE.
  - In the same edge: sum<=final partial-sum value, cout<=final carry.
- DONE:
  - done=1, busy=0, lasts exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge k -> done=1 during the cycle after edge k+WIDTH, with sum/cout valid from that same edge.
- start while busy=1 is ignored; a, b and cin changes while busy have no effect.
- sum/cout change only on entry to DONE. They are stable during SHIFT and IDLE.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). All-ones operands with cin=1 give sum=all-ones, cout=1.
- Reset mid-operation: the operation is abandoned, every output returns to its reset value, and the block is in IDLE once rst_n=1.
- Counter width: clog2(WIDTH), with no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf, 1 bit, reset 0.
  - During the final SHIFT edge, ovf<=(carry into MSB) XOR (carry out of MSB), i.e. signed two's-complement overflow.
  - Updated together with sum/cout.
- Undefined: no ovf port, no associated logic.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - default WIDTH constant.
- One natural sub-module: full_adder, a 1-bit sum/carry cell built from two half-adder stages plus an OR.
  - Instantiated once.
  - Its carry feeds the carry flop; its sum feeds the partial-sum MSB.

Test Plan:
- Reset: hold rst_n=0 -> busy=0, done=0, sum=0, cout=0. Release, idle 5 cycles -> outputs unchanged.
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start at edge k:
  - sum=8'h7F, cout=0;
  - done high only during the cycle after edge k+8;
  - busy high for exactly 8 cycles.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- Operand/start changes while busy:
  - start pulsed mid-SHIFT with different a/b -> ignored, original result returned.
  - start asserted during DONE with a=8'h10, b=8'h20 -> second done exactly 9 cycles after the first, with sum=8'h30.
- Reset mid-operation: assert rst_n=0 at bit 4 of an add -> outputs go to 0 immediately, no done pulse. The next add completes correctly.
- With SERIAL_ADDER_OVF_EN:
  - a=8'h7F, b=8'h01 -> ovf=1, sum=8'h80.
  - a=8'h80, b=8'hFF -> ovf=1, cout=1.
  - a=8'h05, b=8'hFB -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a. Backpressure: n/a.
// Holds FSM encodings, the default width and a counter-width helper.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int cnt_bits(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full adder cell: two half-adder stages whose carries are ORed.
// Latency: combinational. Backpressure: none.
// The top feeds it one operand bit pair plus the registered carry per clock.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  always_comb begin
    ha1_s = a ^ b;
    ha1_c = a & b;
    s     = ha1_s ^ ci;
    ha2_c = ha1_s & ci;
    co    = ha1_c | ha2_c;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_OVF_EN adds a signed-overflow output.
// Latency: done pulses the cycle after edge k+WIDTH for a start accepted at edge k.
// Backpressure: start is ignored while busy; a new start may be accepted during done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] psum_nxt;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    psum_d   = psum_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    psum_nxt = {fa_s, psum_q[WIDTH-1:1]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          psum_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        psum_d  = psum_nxt;
        carry_d = fa_c;
        if (cnt_q == LAST_BIT) begin
          // Counter parks at zero rather than stepping past WIDTH-1.
          cnt_d   = '0;
          sum_d   = psum_nxt;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB cell on this last step.
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results, monitor checks each done.
// Also covers reset values, output stability, busy length, back-to-back and mid-op reset.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected entry per done pulse.
  int           busy_cnt  = 0;
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_sum  = sum;
      prev_cout = cout;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        chk("done_expected", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", busy_cnt, W);
          chk("busy_in_done", 32'(busy), 0);
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.o));
`endif
        end
        busy_cnt = 0;
      end else begin
        chk("sum_stable", 32'(sum), 32'(prev_sum));
        chk("cout_stable", 32'(cout), 32'(prev_cout));
        if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
          chk("missing_done", cyc, sb_q[0].due);
          void'(sb_q.pop_front());
        end
      end
      prev_sum  = sum;
      prev_cout = cout;
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    e.s   = es;
    e.c   = ec;
    e.o   = eo;
    e.due = cyc + 1 + W;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Operand changes while busy must not matter.
    a     = ~ia;
    b     = ~ib;
    cin   = ~ic;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_sum", 32'(sum), 0);

    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_idle();

    // start mid-SHIFT with other operands is ignored
    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // back-to-back: second start lands in the DONE cycle
    issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    repeat (W - 1) @(negedge clk);
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    wait_idle();

    // reset in the middle of an add
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", 32'(ovf), 0);
`endif
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_idle();

`ifdef SERIAL_ADDER_OVF_EN
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_idle();
    issue(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    wait_idle();
    issue(8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
